// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution x-memory stream controller.
package conv_pkg;

  // Controller states, one per phase of the per-output handshake.
  typedef enum logic [2:0] {
    ST_FILL        = 3'd0,
    ST_START       = 3'd1,
    ST_WAIT_RES    = 3'd2,
    ST_WAIT_ACCEPT = 3'd3,
    ST_FETCH       = 3'd4,
    ST_DONE        = 3'd5
  } state_t;

  // Number of valid-convolution outputs produced from one frame.
  function automatic int num_out(input int x_size, input int f_size);
    return x_size - f_size + 1;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Modulo-N pointer with enable, synchronous clear and wrap flag.
// N need not be a power of two: the wrap is an explicit compare.
module ring_ptr #(
  parameter int N = 32,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] ptr_o,
  output logic         wrap_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;
  logic         at_last_s;

  assign at_last_s = (ptr_q == W'(N - 1));

  // Next pointer: clear has priority, otherwise advance and wrap at N-1.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = at_last_s ? '0 : ptr_q + W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign wrap_o = en_i && !clr_i && at_last_s;

endmodule

// File: rtl/ctrl_xmem_stream.sv
// Control for the circular convolution x-memory: fills the window from the
// input stream, launches one MAC pass per output and runs the output
// handshake, overlapping the next sample write with output acceptance.
module ctrl_xmem_stream
  import conv_pkg::*;
#(
  parameter  int X_SIZE  = 128,
  parameter  int F_SIZE  = 32,
  parameter  int ADDR_W  = $clog2(F_SIZE),
  localparam int NUM_OUT = num_out(X_SIZE, F_SIZE),
  localparam int CNT_W   = $clog2(NUM_OUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              xmem_wr_en,
  output logic [ADDR_W-1:0] xmem_wr_addr,
  output logic [ADDR_W-1:0] xmem_base,
  output logic              conv_start,
  input  logic              res_valid,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              xmem_full,
  output logic              conv_done,
  output logic [CNT_W-1:0]  out_count
);

  localparam int FILL_W = $clog2(F_SIZE + 1);

  state_t            state_q;
  logic [FILL_W-1:0] fill_cnt_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic              xmem_full_q;
  logic [ADDR_W-1:0] xmem_base_q;

  logic              s_ready_s;
  logic              wr_en_s;
  logic              last_out_s;
  logic [ADDR_W-1:0] wr_ptr_s;
  logic              ptr_clr_s;
  logic              unused_wr_wrap;

  assign last_out_s = (out_cnt_q == CNT_W'(NUM_OUT - 1));
  assign wr_en_s    = s_valid && s_ready_s;
  assign ptr_clr_s  = (state_q == ST_DONE);

  // Input acceptance: open while filling/fetching, and during output
  // acceptance only when another output will follow (overlap path).
  always_comb begin
    s_ready_s = 1'b0;
    case (state_q)
      ST_FILL:        s_ready_s = 1'b1;
      ST_FETCH:       s_ready_s = 1'b1;
      ST_WAIT_ACCEPT: s_ready_s = m_ready && !last_out_s;
      default:        s_ready_s = 1'b0;
    endcase
  end

  ring_ptr #(
    .N (F_SIZE),
    .W (ADDR_W)
  ) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (ptr_clr_s),
    .en_i   (wr_en_s),
    .ptr_o  (wr_ptr_s),
    .wrap_o (unused_wr_wrap)
  );

  // Main FSM with fill/output counters, window base and full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      fill_cnt_q  <= '0;
      out_cnt_q   <= '0;
      xmem_full_q <= 1'b0;
      xmem_base_q <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (wr_en_s) begin
            fill_cnt_q <= fill_cnt_q + FILL_W'(1);
            if (fill_cnt_q == FILL_W'(F_SIZE - 1)) begin
              xmem_full_q <= 1'b1;
              state_q     <= ST_START;
            end
          end
        end
        ST_START: begin
          // The write pointer now addresses the oldest sample of the window.
          xmem_base_q <= wr_ptr_s;
          state_q     <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            state_q <= ST_WAIT_ACCEPT;
          end
        end
        ST_WAIT_ACCEPT: begin
          if (m_ready) begin
            out_cnt_q <= out_cnt_q + CNT_W'(1);
            if (last_out_s) begin
              state_q <= ST_DONE;
            end else if (wr_en_s) begin
              state_q <= ST_START;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (wr_en_s) begin
            state_q <= ST_START;
          end
        end
        ST_DONE: begin
          fill_cnt_q  <= '0;
          out_cnt_q   <= '0;
          xmem_full_q <= 1'b0;
          state_q     <= ST_FILL;
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign s_ready      = s_ready_s;
  assign xmem_wr_en   = wr_en_s;
  assign xmem_wr_addr = wr_ptr_s;
  assign xmem_base    = xmem_base_q;
  assign conv_start   = (state_q == ST_START);
  assign m_valid      = (state_q == ST_WAIT_ACCEPT);
  assign conv_done    = (state_q == ST_DONE);
  assign xmem_full    = xmem_full_q;
  assign out_count    = out_cnt_q;

endmodule

// File: tb/tb_ctrl_xmem_stream.sv
// Self-checking bench for ctrl_xmem_stream with X_SIZE=8, F_SIZE=3.
module tb_ctrl_xmem_stream;

  localparam int X_SIZE  = 8;
  localparam int F_SIZE  = 3;
  localparam int ADDR_W  = 2;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic              xmem_wr_en;
  logic [ADDR_W-1:0] xmem_wr_addr;
  logic [ADDR_W-1:0] xmem_base;
  logic              conv_start;
  logic              res_valid;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              xmem_full;
  logic              conv_done;
  logic [CNT_W-1:0]  out_count;

  always #5 clk = ~clk;

  ctrl_xmem_stream #(
    .X_SIZE (X_SIZE),
    .F_SIZE (F_SIZE),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .xmem_wr_en   (xmem_wr_en),
    .xmem_wr_addr (xmem_wr_addr),
    .xmem_base    (xmem_base),
    .conv_start   (conv_start),
    .res_valid    (res_valid),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .xmem_full    (xmem_full),
    .conv_done    (conv_done),
    .out_count    (out_count)
  );

  // MAC model: result pulse two cycles after conv_start, plus injected spurious pulses.
  logic [1:0] mac_sr;
  logic       spur = 1'b0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mac_sr <= 2'b00;
    else       mac_sr <= {mac_sr[0], conv_start};
  end
  assign res_valid = mac_sr[1] | spur;

  int n_vec = 0;
  int n_err = 0;
  int n_wr, n_start, n_done;
  int m_fill;
  logic [ADDR_W-1:0] m_ptr;
  logic [ADDR_W-1:0] base_q[$];
  logic [ADDR_W-1:0] exp_base;
  bit   pend_base;
  logic [CNT_W-1:0] done_cnt;

  logic obs_s_ready, obs_wr_en, obs_m_valid, obs_start, obs_done, obs_full;
  logic [ADDR_W-1:0] obs_addr;
  logic [CNT_W-1:0]  obs_cnt;

  task automatic clear_model();
    m_ptr = '0; m_fill = 0; base_q.delete(); pend_base = 1'b0;
    n_wr = 0; n_start = 0; n_done = 0; done_cnt = '0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; m_ready = 1'b0; spur = 1'b0;
    reset = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One clock: sample outputs on the falling edge, run the write-address and
  // window-base scoreboard, then return just after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    obs_s_ready = s_ready; obs_wr_en = xmem_wr_en; obs_addr = xmem_wr_addr;
    obs_m_valid = m_valid; obs_start = conv_start; obs_done = conv_done;
    obs_full = xmem_full; obs_cnt = out_count;
    if (pend_base) begin
      pend_base = 1'b0;
      exp_base = base_q.pop_front();
      n_vec++;
      if (xmem_base !== exp_base) begin
        n_err++;
        $display("FAIL xmem_base: got %0d, expected %0d", xmem_base, exp_base);
      end
    end
    if (conv_start) begin
      n_start++;
      n_vec++;
      if (base_q.size() == 0) begin
        n_err++;
        $display("FAIL conv_start_unexpected: got 1, expected 0");
      end else begin
        pend_base = 1'b1;
      end
    end
    if (xmem_wr_en) begin
      n_wr++;
      n_vec++;
      if (xmem_wr_addr !== m_ptr) begin
        n_err++;
        $display("FAIL xmem_wr_addr: got %0d, expected %0d", xmem_wr_addr, m_ptr);
      end
      m_ptr = (m_ptr == ADDR_W'(F_SIZE - 1)) ? '0 : m_ptr + ADDR_W'(1);
      m_fill++;
      if (m_fill >= F_SIZE) base_q.push_back(m_ptr);
    end
    if (conv_done) begin
      n_done++;
      done_cnt = out_count;
      m_ptr = '0; m_fill = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    s_valid = 1'b1;
    cycle(); cycle();
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++; if (xmem_wr_addr !== 2'd0) begin n_err++; $display("FAIL rst_wr_addr: got %0d, expected 0", xmem_wr_addr); end
    n_vec++; if (m_valid !== 1'b0 || conv_start !== 1'b0 || conv_done !== 1'b0 || xmem_full !== 1'b0 || xmem_wr_en !== 1'b0) begin
      n_err++; $display("FAIL rst_flags: got %b%b%b%b%b, expected 00000", m_valid, conv_start, conv_done, xmem_full, xmem_wr_en);
    end
    n_vec++; if (out_count !== 3'd0 || xmem_base !== 2'd0) begin n_err++; $display("FAIL rst_counts: got %0d/%0d, expected 0/0", out_count, xmem_base); end
    do_reset();
    cycle();
    n_vec++; if (obs_s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready: got %b, expected 1", obs_s_ready); end
  endtask

  task automatic test_stream();
    do_reset();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 200 && n_done == 0; i++) cycle();
    s_valid = 1'b0; m_ready = 1'b0;
    cycle();
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL stream_done_pulses: got %0d, expected 1", n_done); end
    n_vec++; if (n_start !== 6) begin n_err++; $display("FAIL stream_starts: got %0d, expected 6", n_start); end
    n_vec++; if (n_wr !== X_SIZE) begin n_err++; $display("FAIL stream_writes: got %0d, expected %0d", n_wr, X_SIZE); end
    n_vec++; if (done_cnt !== 3'd6) begin n_err++; $display("FAIL stream_out_count: got %0d, expected 6", done_cnt); end
    n_vec++; if (base_q.size() !== 0) begin n_err++; $display("FAIL stream_bases_left: got %0d, expected 0", base_q.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 50 && !obs_m_valid; i++) cycle();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cycle();
      n_vec++;
      if (obs_m_valid !== 1'b1 || obs_s_ready !== 1'b0 || obs_wr_en !== 1'b0 || obs_addr !== 2'd0) begin
        n_err++;
        $display("FAIL bp_hold: got mv=%b sr=%b we=%b addr=%0d, expected 1 0 0 0", obs_m_valid, obs_s_ready, obs_wr_en, obs_addr);
      end
    end
    n_vec++; if (n_wr !== 3) begin n_err++; $display("FAIL bp_writes: got %0d, expected 3", n_wr); end
    m_ready = 1'b1;
    cycle();
    n_vec++; if (obs_wr_en !== 1'b1) begin n_err++; $display("FAIL bp_overlap_write: got %b, expected 1", obs_wr_en); end
    s_valid = 1'b0; m_ready = 1'b0;
    cycle();
    n_vec++; if (obs_start !== 1'b1) begin n_err++; $display("FAIL bp_overlap_start: got %b, expected 1", obs_start); end
  endtask

  task automatic goto_fetch();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 50 && !obs_start; i++) cycle();
    s_valid = 1'b0;
    for (int i = 0; i < 50 && !obs_m_valid; i++) cycle();
  endtask

  task automatic test_fetch_stall();
    do_reset();
    obs_start = 1'b0; obs_m_valid = 1'b0;
    goto_fetch();
    n_vec++; if (obs_m_valid !== 1'b1 || obs_wr_en !== 1'b0) begin n_err++; $display("FAIL fetch_entry: got mv=%b we=%b, expected 1 0", obs_m_valid, obs_wr_en); end
    repeat (4) begin
      cycle();
      n_vec++;
      if (obs_start !== 1'b0 || obs_s_ready !== 1'b1) begin
        n_err++; $display("FAIL fetch_idle: got start=%b sr=%b, expected 0 1", obs_start, obs_s_ready);
      end
    end
    s_valid = 1'b1;
    cycle();
    n_vec++; if (obs_wr_en !== 1'b1) begin n_err++; $display("FAIL fetch_write: got %b, expected 1", obs_wr_en); end
    s_valid = 1'b0;
    cycle();
    n_vec++; if (obs_start !== 1'b1) begin n_err++; $display("FAIL fetch_start: got %b, expected 1", obs_start); end
  endtask

  task automatic test_last_output();
    do_reset();
    s_valid = 1'b1; m_ready = 1'b1;
    obs_m_valid = 1'b0; obs_cnt = '0;
    for (int i = 0; i < 200 && !(obs_m_valid && obs_cnt == 3'd5); i++) cycle();
    n_vec++; if (obs_s_ready !== 1'b0 || obs_wr_en !== 1'b0 || obs_addr !== 2'd2) begin
      n_err++; $display("FAIL last_accept: got sr=%b we=%b addr=%0d, expected 0 0 2", obs_s_ready, obs_wr_en, obs_addr);
    end
    cycle();
    n_vec++; if (obs_done !== 1'b1 || obs_addr !== 2'd2 || obs_cnt !== 3'd6 || obs_s_ready !== 1'b0) begin
      n_err++; $display("FAIL last_done: got done=%b addr=%0d cnt=%0d sr=%b, expected 1 2 6 0", obs_done, obs_addr, obs_cnt, obs_s_ready);
    end
    cycle();
    n_vec++; if (obs_done !== 1'b0 || obs_s_ready !== 1'b1 || obs_cnt !== 3'd0 || obs_addr !== 2'd0 || obs_full !== 1'b0) begin
      n_err++; $display("FAIL last_refill: got done=%b sr=%b cnt=%0d addr=%0d full=%b, expected 0 1 0 0 0", obs_done, obs_s_ready, obs_cnt, obs_addr, obs_full);
    end
    s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit prev_wr;
    do_reset();
    s_valid = 1'b1; m_ready = 1'b1;
    obs_start = 1'b0;
    for (int i = 0; i < 50 && !obs_start; i++) cycle();
    s_valid = 1'b0;
    cycle();
    n_vec++; if (obs_full !== 1'b1) begin n_err++; $display("FAIL ar_full_before: got %b, expected 1", obs_full); end
    reset = 1'b1;
    #1;
    n_vec++; if (m_valid !== 1'b0 || conv_start !== 1'b0 || xmem_full !== 1'b0) begin
      n_err++; $display("FAIL ar_immediate: got mv=%b cs=%b full=%b, expected 0 0 0", m_valid, conv_start, xmem_full);
    end
    @(posedge clk);
    #1;
    clear_model();
    reset = 1'b0;
    s_valid = 1'b1;
    prev_wr = 1'b0; obs_start = 1'b0;
    for (int i = 0; i < 50 && !obs_start; i++) begin
      prev_wr = obs_wr_en;
      cycle();
    end
    n_vec++; if (obs_start !== 1'b1 || n_wr !== 3 || prev_wr !== 1'b1) begin
      n_err++; $display("FAIL ar_refill_start: got start=%b writes=%0d prev_wr=%b, expected 1 3 1", obs_start, n_wr, prev_wr);
    end
    s_valid = 1'b0;
    cycle();
  endtask

  task automatic test_spurious();
    do_reset();
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    cycle();
    n_vec++; if (obs_m_valid !== 1'b0 || obs_s_ready !== 1'b1) begin
      n_err++; $display("FAIL spur_fill: got mv=%b sr=%b, expected 0 1", obs_m_valid, obs_s_ready);
    end
    obs_start = 1'b0; obs_m_valid = 1'b0;
    goto_fetch();
    spur = 1'b1;
    cycle();
    spur = 1'b0;
    cycle();
    n_vec++; if (obs_m_valid !== 1'b0 || obs_s_ready !== 1'b1 || obs_start !== 1'b0) begin
      n_err++; $display("FAIL spur_fetch: got mv=%b sr=%b cs=%b, expected 0 1 0", obs_m_valid, obs_s_ready, obs_start);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_stream();
    test_backpressure();
    test_fetch_stall();
    test_last_output();
    test_async_reset();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
